alu_mdu: RTL and testbench



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/mdu_iter.sv | 86 ++++++++
 rtl/alu_mdu.sv | 216 +++++++++++++++++++++
 tb/tb_alu_mdu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_mdu execute-stage ALU with RV32M support.
package alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SHAMT_W        = $clog2(DATA_WIDTH_DEF);
  localparam int CNT_W          = $clog2(DATA_WIDTH_DEF) + 1;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_XOR    = 5'b00011,
    OP_SLL    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_SUB    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_EQ     = 5'b01000,
    OP_GE     = 5'b01001,
    OP_LTU    = 5'b01010,
    OP_LT     = 5'b01100,
    OP_NE     = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // True for the eight multiply/divide codes (10xxx); 11xxx is reserved.
  function automatic logic is_mdu_op(input logic [4:0] op);
    return op[4] & ~op[3];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Unsigned iterative engine: shift-add multiplier and restoring divider sharing one
// hi/lo register pair. One step per cycle; last flags the final step's combinational result.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CW         = CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] hi_nxt,
  output logic [DATA_WIDTH-1:0] lo_nxt
);

  localparam int W = DATA_WIDTH;

  logic          run_r;
  logic          div_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  hi_r;
  logic [W-1:0]  lo_r;
  logic [W-1:0]  b_r;

  logic [W:0]    add_s;
  logic [W:0]    rem_sh_s;
  logic          ge_s;
  logic [W-1:0]  diff_s;

  // Multiply: hi accumulates, lo holds the multiplier and collects product low bits.
  // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
  assign add_s    = {1'b0, hi_r} + {1'b0, (lo_r[0] ? b_r : {W{1'b0}})};
  assign rem_sh_s = {hi_r, lo_r[W-1]};
  assign ge_s     = (rem_sh_s >= {1'b0, b_r});
  assign diff_s   = rem_sh_s[W-1:0] - b_r;
  assign last     = run_r && (cnt_r == CW'(DATA_WIDTH - 1));

  // Next value of the datapath registers for one iteration.
  always_comb begin
    hi_nxt = hi_r;
    lo_nxt = lo_r;
    if (div_r) begin
      if (ge_s) begin
        hi_nxt = diff_s;
        lo_nxt = {lo_r[W-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh_s[W-1:0];
        lo_nxt = {lo_r[W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_s[W:1];
      lo_nxt = {add_s[0], lo_r[W-1:1]};
    end
  end

  // Engine registers: load on start, step while running, stop after the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r <= 1'b0;
      div_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
      hi_r  <= {W{1'b0}};
      lo_r  <= {W{1'b0}};
      b_r   <= {W{1'b0}};
    end else if (start) begin
      run_r <= 1'b1;
      div_r <= is_div;
      cnt_r <= {CW{1'b0}};
      hi_r  <= {W{1'b0}};
      lo_r  <= opa;
      b_r   <= opb;
    end else if (run_r) begin
      hi_r  <= hi_nxt;
      lo_r  <= lo_nxt;
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      run_r <= ~last;
    end else begin
      run_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with RV32M multiply/divide, valid/ready on both sides.
// Define ALU_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = (DATA_WIDTH == DATA_WIDTH_DEF) ? SHAMT_W : $clog2(DATA_WIDTH);

  state_t         state_r, state_nxt_s;
  logic           out_valid_r;
  logic [W-1:0]   result_r;
  logic           m_div_r, m_hi_r, m_neg_r;

  alu_op_t        op_s;
  logic           accept_s, iter_s, start_s;
  logic [SW-1:0]  shamt_s;
  logic [W-1:0]   basic_s, single_s, fix_s, qr_s;
  logic           div_zero_s, div_ovf_s;
  logic           sa_s, sb_s;
  logic [W-1:0]   maga_s, magb_s;
  logic           mdu_last_s;
  logic [W-1:0]   hi_nxt_s, lo_nxt_s;
  logic [2*W-1:0] prod_s;

  assign op_s       = alu_op_t'(Operation[4:0]);
  assign shamt_s    = SrcB[SW-1:0];
  assign in_ready   = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready;
  assign start_s    = accept_s && iter_s;
  assign busy       = (state_r == CALC);
  assign out_valid  = out_valid_r;
  assign ALUResult  = result_r;
  assign div_zero_s = (SrcB == {W{1'b0}});
  assign div_ovf_s  = !Operation[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == {W{1'b1}});

`ifdef ALU_FAST_MUL_EN
  logic [W:0]     fa_s, fb_s;
  logic [2*W-1:0] fp_s;
  assign fa_s = {((op_s == OP_MULH) || (op_s == OP_MULHSU)) & SrcA[W-1], SrcA};
  assign fb_s = {(op_s == OP_MULH) & SrcB[W-1], SrcB};
  assign fp_s = {{(W-1){fa_s[W]}}, fa_s} * {{(W-1){fb_s[W]}}, fb_s};
`endif

  // Decide whether an M op needs the iterative engine or resolves in one cycle.
  always_comb begin
    iter_s = 1'b0;
    if (is_mdu_op(Operation[4:0])) begin
      if (Operation[2]) begin
        iter_s = !div_zero_s && !div_ovf_s;
      end else begin
`ifdef ALU_FAST_MUL_EN
        iter_s = 1'b0;
`else
        iter_s = 1'b1;
`endif
      end
    end else begin
      iter_s = 1'b0;
    end
  end

  // Basic integer ops.
  always_comb begin
    case (op_s)
      OP_AND:  basic_s = SrcA & SrcB;
      OP_OR:   basic_s = SrcA | SrcB;
      OP_ADD:  basic_s = SrcA + SrcB;
      OP_XOR:  basic_s = SrcA ^ SrcB;
      OP_SLL:  basic_s = SrcA << shamt_s;
      OP_SRL:  basic_s = SrcA >> shamt_s;
      OP_SUB:  basic_s = SrcA - SrcB;
      OP_SRA:  basic_s = $signed(SrcA) >>> shamt_s;
      OP_EQ:   basic_s = {{(W-1){1'b0}}, (SrcA == SrcB)};
      OP_GE:   basic_s = {{(W-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
      OP_LTU:  basic_s = {{(W-1){1'b0}}, (SrcA < SrcB)};
      OP_LT:   basic_s = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_NE:   basic_s = {{(W-1){1'b0}}, (SrcA != SrcB)};
      default: basic_s = {W{1'b0}};
    endcase
  end

  // Every latency-1 result: basic ops, reserved codes, divide special cases, fast multiply.
  always_comb begin
    single_s = {W{1'b0}};
    if (!Operation[4]) begin
      single_s = basic_s;
    end else if (Operation[3]) begin
      single_s = {W{1'b0}};
    end else if (Operation[2]) begin
      if (div_zero_s) begin
        single_s = Operation[1] ? SrcA : {W{1'b1}};
      end else if (div_ovf_s) begin
        single_s = Operation[1] ? {W{1'b0}} : SrcA;
      end else begin
        single_s = {W{1'b0}};
      end
    end else begin
`ifdef ALU_FAST_MUL_EN
      single_s = (op_s == OP_MUL) ? fp_s[W-1:0] : fp_s[2*W-1:W];
`else
      single_s = {W{1'b0}};
`endif
    end
  end

  // Sign flags count only for operands the op treats as signed; MUL low half is sign-agnostic.
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    if (Operation[2]) begin
      sa_s = !Operation[0] & SrcA[W-1];
      sb_s = !Operation[0] & SrcB[W-1];
    end else begin
      sa_s = ((Operation[1:0] == 2'b01) || (Operation[1:0] == 2'b10)) & SrcA[W-1];
      sb_s = (Operation[1:0] == 2'b01) & SrcB[W-1];
    end
  end

  assign maga_s = sa_s ? ({W{1'b0}} - SrcA) : SrcA;
  assign magb_s = sb_s ? ({W{1'b0}} - SrcB) : SrcB;

  mdu_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CW         ($clog2(DATA_WIDTH) + 1)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .is_div (Operation[2]),
    .opa    (maga_s),
    .opb    (magb_s),
    .last   (mdu_last_s),
    .hi_nxt (hi_nxt_s),
    .lo_nxt (lo_nxt_s)
  );

  // Sign fix-up and half selection on the engine's final step.
  always_comb begin
    prod_s = m_neg_r ? ({(2*W){1'b0}} - {hi_nxt_s, lo_nxt_s}) : {hi_nxt_s, lo_nxt_s};
    qr_s   = m_hi_r ? hi_nxt_s : lo_nxt_s;
    if (m_div_r) begin
      fix_s = m_neg_r ? ({W{1'b0}} - qr_s) : qr_s;
    end else begin
      fix_s = m_hi_r ? prod_s[2*W-1:W] : prod_s[W-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start_s ? CALC : IDLE;
      CALC:    state_nxt_s = mdu_last_s ? IDLE : CALC;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Capture how the engine's raw output is to be interpreted for the op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_div_r <= 1'b0;
      m_hi_r  <= 1'b0;
      m_neg_r <= 1'b0;
    end else if (start_s) begin
      m_div_r <= Operation[2];
      m_hi_r  <= Operation[2] ? Operation[1] : (Operation[1:0] != 2'b00);
      m_neg_r <= (Operation[2] && Operation[1]) ? sa_s : (sa_s ^ sb_s);
    end else begin
      m_div_r <= m_div_r;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {W{1'b0}};
    end else if (accept_s && !iter_s) begin
      out_valid_r <= 1'b1;
      result_r    <= single_s;
    end else if (mdu_last_s) begin
      out_valid_r <= 1'b1;
      result_r    <= fix_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: driver pushes expected results, a monitor pops and checks them.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic [4:0]  Operation = 5'd0;
  logic        in_ready, out_valid, busy;
  logic [31:0] ALUResult;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rmode = 0;
  bit   shown = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mdu #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .busy(busy)
  );

  // Reference model straight from the instruction definitions.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, za, zb, p;
    int sh;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    sh = int'(b[4:0]);
    case (op)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return a + b;
      5'b00011: return a ^ b;
      5'b00100: return a << sh;
      5'b00101: return a >> sh;
      5'b00110: return a - b;
      5'b00111: begin p = sa >>> sh; return p[31:0]; end
      5'b01000: return (a == b) ? 32'd1 : 32'd0;
      5'b01001: return (sa >= sb) ? 32'd1 : 32'd0;
      5'b01010: return (za < zb) ? 32'd1 : 32'd0;
      5'b01100: return (sa < sb) ? 32'd1 : 32'd0;
      5'b01101: return (a != b) ? 32'd1 : 32'd0;
      5'b10000: begin p = za * zb; return p[31:0]; end
      5'b10001: begin p = sa * sb; return p[63:32]; end
      5'b10010: begin p = sa * zb; return p[63:32]; end
      5'b10011: begin p = za * zb; return p[63:32]; end
      5'b10100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      5'b10101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'b10110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      5'b10111: return (b == 32'd0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4:3] != 2'b10) return 1;
    if (op[2]) begin
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef ALU_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present an op from posedge+1 and wait (bounded) for acceptance.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    Operation = op;
    SrcA = a;
    SrcB = b;
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.exp = exp;
        e.lat = lat_of(op, a, b);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: op %b never accepted", op);
    in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, model(op, a, b));
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Consumer readiness: random, always ready, or stalled.
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      1: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: latency on first presentation, value every presented cycle, engine flags in CALC.
  initial forever begin
    int d;
    @(negedge clk);
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", ALUResult, 32'hxxxx_xxxx);
        end else begin
          if (!shown) begin
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            shown = 1'b1;
          end
          chk("result", ALUResult, q[0].exp);
          if (out_ready) begin
            void'(q.pop_front());
            shown = 1'b0;
          end
        end
      end else if (q.size() > 0) begin
        d = cyc - q[0].acc;
        if (d >= 1 && d < q[0].lat) begin
          chk("busy_in_calc", 32'(busy), 32'd1);
          chk("in_ready_in_calc", 32'(in_ready), 32'd0);
        end else if (d >= q[0].lat) begin
          chk("missing_result", 32'(out_valid), 32'd1);
          void'(q.pop_front());
          shown = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [4:0] op;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    rmode = 1;
    issue(5'b00010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    issue(5'b00110, 32'd5, 32'd7, 32'hFFFF_FFFE);
    issue(5'b00111, 32'h8000_0000, 32'h24, 32'hF800_0000);
    issue(5'b01010, 32'd1, 32'hFFFF_FFFF, 32'd1);
    issue(5'b01100, 32'd1, 32'hFFFF_FFFF, 32'd0);
    issue(5'b11010, 32'd9, 32'd9, 32'd0);
    issue(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue(5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue(5'b10101, 32'd7, 32'd0, 32'hFFFF_FFFF);
    issue(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Consumer stall: result must hold and no new op may be taken.
    issue(5'b00010, 32'd10, 32'd20, 32'd30);
    rmode = 2;
    out_ready = 1'b0;
    Operation = 5'b00011;
    SrcA = 32'hF0F0_F0F0;
    SrcB = 32'h0FF0_0FF0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    rmode = 1;
    issue(5'b00011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);

    // Reset during the 12th DIVU iteration aborts silently.
    issue(5'b10101, 32'd1000, 32'd7, 32'd142);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    shown = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(5'b00010, 32'd2, 32'd3, 32'd5);

    // Randomized traffic with random consumer stalls and issue gaps.
    rmode = 0;
    for (int i = 0; i < 200; i++) begin
      op = 5'($urandom_range(0, 31));
      issue_m(op, rnd_val(), rnd_val());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    rmode = 1;
    for (int n = 0; n < 300 && q.size() > 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
